// File: rtl/zmips_pkg.sv
// Shared types and constants for the zmips register-file write path.
package zmips_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned WORD_W  = 32;

    typedef logic [REG_AW-1:0] regaddr_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam regaddr_t REG_PC_SHADOW = 5'd30;
    localparam regaddr_t REG_PC        = 5'd31;

    // One pending regfile write: destination plus data
    typedef struct packed {
        regaddr_t addr;
        word_t    data;
    } wb_entry_t;

    // r30/r31 mirror the PC and are never written through the regfile port
    function automatic logic is_pc_reg(input regaddr_t addr);
        return (addr == REG_PC_SHADOW) || (addr == REG_PC);
    endfunction

endpackage

// File: rtl/zmips_tag_fifo.sv
// In-order FIFO of destination registers for outstanding loads.
module zmips_tag_fifo
    import zmips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  regaddr_t push_data,
    input  logic     pop,
    output regaddr_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    regaddr_t      mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/zmips_wb_arbiter.sv
// Merges ALU results and in-order load returns onto the single regfile
// write port, and tracks pending load destinations for hazard detection.
module zmips_wb_arbiter
    import zmips_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_addr,
    output logic        ld_issue_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        wr,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] busy
);

    logic      fifo_full;
    logic      fifo_empty;
    regaddr_t  tag_head;

    logic      hold_valid_q;
    wb_entry_t hold_q;
    logic      hold_valid_d;
    wb_entry_t hold_d;

    logic      sel_valid;
    logic      sel_is_load;
    wb_entry_t sel;
    logic [31:0] busy_d;

    logic      ld_accept;
    logic      issue_accept;

    // A return may only be taken if it has a slot: write port now or hold
    assign ld_ready       = !fifo_empty && (!hold_valid_q || !alu_valid);
    assign ld_accept      = ld_valid && ld_ready;
    assign ld_issue_ready = !fifo_full && !busy[ld_issue_addr];
    assign issue_accept   = ld_issue && ld_issue_ready;

    zmips_tag_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_accept),
        .push_data (ld_issue_addr),
        .pop       (ld_accept),
        .head      (tag_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port selection: ALU, then hold, then a fresh load return
    always_comb begin
        sel_valid    = 1'b0;
        sel_is_load  = 1'b0;
        sel          = '0;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;

        if (alu_valid) begin
            sel_valid = 1'b1;
            sel.addr  = alu_addr;
            sel.data  = alu_data;
            if (ld_accept) begin
                hold_valid_d = 1'b1;
                hold_d.addr  = tag_head;
                hold_d.data  = ld_data;
            end
        end else if (hold_valid_q) begin
            sel_valid    = 1'b1;
            sel_is_load  = 1'b1;
            sel          = hold_q;
            hold_valid_d = ld_accept;
            if (ld_accept) begin
                hold_d.addr = tag_head;
                hold_d.data = ld_data;
            end
        end else if (ld_accept) begin
            sel_valid   = 1'b1;
            sel_is_load = 1'b1;
            sel.addr    = tag_head;
            sel.data    = ld_data;
        end
    end

    // Scoreboard: clear on load writeback, set on accepted issue
    always_comb begin
        busy_d = busy;
        if (sel_valid && sel_is_load) begin
            busy_d[sel.addr] = 1'b0;
        end
        if (issue_accept && !is_pc_reg(ld_issue_addr)) begin
            busy_d[ld_issue_addr] = 1'b1;
        end
        busy_d[31:30] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            busy         <= '0;
            wr           <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            busy         <= busy_d;
            wr           <= sel_valid && !is_pc_reg(sel.addr);
            if (sel_valid) begin
                wr_addr <= sel.addr;
                wr_data <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_zmips_wb_arbiter.sv
// Directed bench for the regfile write-side arbiter.
module tb_zmips_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_addr;
    logic        ld_issue_ready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        wr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    int vectors;
    int errors;

    zmips_wb_arbiter #(
        .LD_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .ld_issue       (ld_issue),
        .ld_issue_addr  (ld_issue_addr),
        .ld_issue_ready (ld_issue_ready),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .wr             (wr),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wr"}, 32'(wr), 32'd1);
        chk({tag, ".addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".data"}, wr_data, d);
    endtask

    initial begin
        logic [4:0] drain_addr [4];
        drain_addr[0] = 5'd2;
        drain_addr[1] = 5'd3;
        drain_addr[2] = 5'd4;
        drain_addr[3] = 5'd9;

        vectors       = 0;
        errors        = 0;
        rst_n         = 1'b0;
        alu_valid     = 1'b0;
        alu_addr      = '0;
        alu_data      = '0;
        ld_issue      = 1'b0;
        ld_issue_addr = '0;
        ld_valid      = 1'b0;
        ld_data       = '0;

        // Reset state
        #1;
        chk("rst.wr", 32'(wr), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.wr_data", wr_data, 32'd0);
        chk("rst.busy", busy, 32'd0);
        chk("rst.ld_ready", 32'(ld_ready), 32'd0);
        chk("rst.ld_issue_ready", 32'(ld_issue_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        chk_wr("alu", 5'd5, 32'hDEADBEEF);
        chk("alu.busy", busy, 32'd0);
        tick();
        chk("alu.wr_once", 32'(wr), 32'd0);

        // Load round trip to r7
        ld_issue = 1'b1; ld_issue_addr = 5'd7;
        #1 chk("rt.issue_ready", 32'(ld_issue_ready), 32'd1);
        tick();
        ld_issue = 1'b0;
        chk("rt.busy_set", busy, 32'h0000_0080);
        tick();
        tick();
        ld_valid = 1'b1; ld_data = 32'h1234;
        #1 chk("rt.ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        chk_wr("rt", 5'd7, 32'h1234);
        chk("rt.busy_clr", busy, 32'd0);
        #1 chk("rt.ld_ready_empty", 32'(ld_ready), 32'd0);
        tick();
        chk("rt.wr_once", 32'(wr), 32'd0);

        // Collision: loads to r10, r11 versus ALU writes
        ld_issue = 1'b1; ld_issue_addr = 5'd10;
        tick();
        ld_issue_addr = 5'd11;
        tick();
        ld_issue = 1'b0;
        chk("col.busy", busy, 32'h0000_0C00);
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        ld_valid = 1'b1; ld_data = 32'hA0;
        #1 chk("col.ld_ready0", 32'(ld_ready), 32'd1);
        tick();
        chk_wr("col.alu3", 5'd3, 32'h33);
        chk("col.busy_held", busy, 32'h0000_0C00);
        alu_addr = 5'd4; alu_data = 32'h44; ld_data = 32'hB0;
        #1 chk("col.ld_ready_refused", 32'(ld_ready), 32'd0);
        tick();
        chk_wr("col.alu4", 5'd4, 32'h44);
        alu_valid = 1'b0;
        #1 chk("col.ld_ready_hold", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        chk_wr("col.hold10", 5'd10, 32'hA0);
        chk("col.busy10", busy, 32'h0000_0800);
        tick();
        chk_wr("col.hold11", 5'd11, 32'hB0);
        chk("col.busy11", busy, 32'd0);
        tick();
        chk("col.idle", 32'(wr), 32'd0);

        // Full FIFO and WAW stall
        ld_issue = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ld_issue_addr = 5'(i);
            #1 chk("full.issue_ok", 32'(ld_issue_ready), 32'd1);
            tick();
        end
        chk("full.busy", busy, 32'h0000_001E);
        ld_issue_addr = 5'd9;
        #1 chk("full.refuse_r9", 32'(ld_issue_ready), 32'd0);
        ld_issue_addr = 5'd2;
        #1 chk("full.refuse_waw", 32'(ld_issue_ready), 32'd0);
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h11;
        tick();
        ld_valid = 1'b0;
        chk_wr("full.ret1", 5'd1, 32'h11);
        chk("full.busy_after1", busy, 32'h0000_001C);
        ld_issue = 1'b1; ld_issue_addr = 5'd9;
        #1 chk("full.accept_r9", 32'(ld_issue_ready), 32'd1);
        tick();
        ld_issue = 1'b0;
        chk("full.busy_r9", busy, 32'h0000_021C);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = 32'h20 + 32'(i);
            tick();
            chk_wr("full.drain", drain_addr[i], 32'h20 + 32'(i));
        end
        ld_valid = 1'b0;
        chk("full.busy_end", busy, 32'd0);
        #1 chk("full.empty", 32'(ld_ready), 32'd0);
        tick();

        // PC registers are never written nor marked busy
        alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 32'h1;
        ld_issue = 1'b1; ld_issue_addr = 5'd30;
        #1 chk("pc.issue_ok", 32'(ld_issue_ready), 32'd1);
        tick();
        alu_valid = 1'b0; ld_issue = 1'b0;
        chk("pc.alu_wr", 32'(wr), 32'd0);
        chk("pc.busy", busy, 32'd0);
        ld_valid = 1'b1; ld_data = 32'h77;
        #1 chk("pc.ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        chk("pc.ld_wr", 32'(wr), 32'd0);
        chk("pc.busy2", busy, 32'd0);
        #1 chk("pc.fifo_empty", 32'(ld_ready), 32'd0);
        tick();

        // Reset mid-flight: two tags, hold full
        ld_issue = 1'b1; ld_issue_addr = 5'd5;
        tick();
        ld_issue_addr = 5'd6;
        tick();
        ld_issue = 1'b0;
        chk("mid.busy", busy, 32'h0000_0060);
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h88;
        ld_valid = 1'b1; ld_data = 32'h55;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk_wr("mid.alu8", 5'd8, 32'h88);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst_busy", busy, 32'd0);
        chk("mid.rst_wr", 32'(wr), 32'd0);
        #3 rst_n = 1'b1;
        ld_valid = 1'b1; ld_issue = 1'b1; ld_issue_addr = 5'd5;
        #1;
        chk("mid.ld_ready", 32'(ld_ready), 32'd0);
        chk("mid.issue_ready", 32'(ld_issue_ready), 32'd1);
        ld_valid = 1'b0; ld_issue = 1'b0;
        tick();
        chk("mid.no_hold_wr", 32'(wr), 32'd0);
        chk("mid.busy_after", busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/zmips_wb_arbiter.md
Name: zmips_wb_arbiter

Overview:
- Write-side controller for zmips_regfile. It merges single-cycle ALU results and variable-latency load returns onto the regfile's single write port (wr, wr_addr, wr_data).
- Tracks loads that have been issued but not yet written back, using an in-order tag FIFO and a per-register busy scoreboard, so decode can detect RAW/WAW hazards.
- Sits between execute/memory and the regfile; decode consumes busy and ld_issue_ready.

Parameters:
- LD_DEPTH, 4, maximum number of outstanding loads (tag FIFO depth); power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_issue  in  1  decode issues a load.
- ld_issue_addr  in  5  destination register of the issued load.
- ld_issue_ready  out  1  load issue accepted when ld_issue && ld_issue_ready.
- ld_valid  in  1  memory presents load data.
- ld_data  in  32  load data; returns arrive in issue order.
- ld_ready  out  1  load return accepted when ld_valid && ld_ready.
- wr  out  1  regfile write enable (registered).
- wr_addr  out  5  regfile write address (registered).
- wr_data  out  32  regfile write data (registered).
- busy  out  32  scoreboard; bit i = register i has a load pending.

Behaviour:
- Reset (async, rst_n=0): wr=0, wr_addr=0, wr_data=0, busy=0, tag FIFO empty, hold register empty. Asserting reset mid-operation discards all outstanding tags and held data; load returns already in flight are the memory side's responsibility to flush.
- All write-port outputs are registered. A result selected in cycle N appears on wr/wr_addr/wr_data in cycle N+1. wr is high for exactly one cycle per write.
- Priority each cycle:
  1. ALU.
  2. Hold register (one entry).
  3. Load return accepted this cycle.
- alu_valid=1: the ALU result is written. An accepted load return goes into hold.
- alu_valid=0, hold full: hold is written. An accepted load return moves into hold in the same cycle.
- alu_valid=0, hold empty: an accepted load return is written directly.
- ld_ready = tag FIFO not empty AND (hold empty OR alu_valid=0).
- A load return pops the oldest tag on acceptance. Its destination address comes from that tag, never from memory.
- ld_issue_ready = tag FIFO not full AND NOT busy[ld_issue_addr]. A load to an already-busy register stalls (WAW).
- Accepted issue: pushes ld_issue_addr onto the tag FIFO and sets busy[addr] on the next edge. Addresses 30 and 31 never set busy.
- A busy bit clears on the edge where its load result is registered onto the write port, so busy drops in the same cycle wr rises for that load.
- Issue and clear can never target the same register in the same cycle, because issue is blocked while that register is busy.
- Issue and return in the same cycle: push and pop both occur; the count is unchanged. Issue while full is blocked even if a pop occurs that cycle.
- Addresses 30 (PC shadow) and 31 (live PC) are not writable:
  - Any selected result with addr 30 or 31 produces wr=0. The slot is still consumed.
  - A load to 30/31 still occupies a tag and is popped normally.
  - busy[31:30] is always 0.
- An ALU write to a busy register is performed as normal and busy is unaffected. Stalling such writes is decode's responsibility.
- Tag FIFO pointers wrap modulo LD_DEPTH. The count is width clog2(LD_DEPTH)+1.

Decomposition:
- zmips_pkg holds:
  - regaddr_t (logic [4:0]);
  - word_t (logic [31:0]);
  - REG_PC_SHADOW = 5'd30 and REG_PC = 5'd31;
  - function is_pc_reg(regaddr_t).
- Sub-module zmips_tag_fifo:
  - parameterised depth, regaddr_t payload;
  - push/pop/full/empty/head;
  - simultaneous push and pop supported.
- Scoreboard, hold register and output register stay in zmips_wb_arbiter.

Test Plan:
- ALU only: alu_valid=1, alu_addr=5, alu_data=32'hDEADBEEF in cycle 0 -> wr=1, wr_addr=5, wr_data=32'hDEADBEEF in cycle 1 only; busy=0 throughout.
- Load round trip: issue addr 7; busy[7]=1 next cycle. Return ld_data=32'h1234 three cycles later -> write to r7 one cycle after acceptance; busy[7] clears in the same cycle wr=1.
- Collision: load return accepted while alu_valid=1 (addr 3) -> r3 written first; the load is written the next cycle from hold. A second return in that next cycle is refused (ld_ready=0) only if the ALU stays valid.
- Full/WAW: issue 4 loads to r1..r4 -> ld_issue_ready=0 on a 5th issue to r9. Issue to busy r2 is also refused. After one return, an issue to r9 is accepted.
- PC registers: ALU write to r31 and load issued to r30 -> wr never asserts for either; busy[31:30]=0; the load tag is popped and the FIFO ends empty.
- Reset mid-flight: 2 loads outstanding, hold full; pulse rst_n low asynchronously -> busy=0, wr=0 immediately; after release, ld_ready=0 and ld_issue_ready=1.
